bcd_field_editor: RTL and testbench

- Parametrised successor to the clock/timer programming controller.
- Edits NUM_FIELDS packed 2-digit BCD fields using a cursor and up/down buttons, with per-field min/max wrap limits.
- New over the previous generation: edits go into a shadow copy that is committed or cancelled; held up/down auto-repeats; an inactivity timeout aborts the edit; a live time source can load the committed fields while idle or editing.
- Sits between the debounced button block and the RTC/timer registers and display mux.

---
 rtl/bcd_field_editor.sv | 200 ++++++++++++++++++++
 tb/tb_bcd_field_editor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_field_editor.sv
// bcd_field_editor: edits NUM_FIELDS packed 2-digit BCD fields through a shadow
// copy, with cursor, auto-repeating up/down, commit/cancel, timeout, ext load.
// Ports: clk, reset (sync, active-high), btn_enter/done/cancel/right/left/up/down
// (debounced levels), ext_load + ext_fields (live values), fields (committed),
// edit_fields (shadow), cursor, editing, commit_pulse, timeout_pulse.
module bcd_field_editor #(
    parameter int NUM_FIELDS = 6,
    parameter logic [8*NUM_FIELDS-1:0] FIELD_MIN =
        {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
    parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX =
        {8'h99, 8'h12, 8'h31, 8'h59, 8'h59, 8'h23},
    parameter logic [8*NUM_FIELDS-1:0] RESET_VAL =
        {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    parameter int TIMEOUT       = 1024,
    parameter int CW            = $clog2(NUM_FIELDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_enter,
    input  logic                    btn_done,
    input  logic                    btn_cancel,
    input  logic                    btn_right,
    input  logic                    btn_left,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    ext_load,
    input  logic [8*NUM_FIELDS-1:0] ext_fields,
    output logic [8*NUM_FIELDS-1:0] fields,
    output logic [8*NUM_FIELDS-1:0] edit_fields,
    output logic [CW-1:0]           cursor,
    output logic                    editing,
    output logic                    commit_pulse,
    output logic                    timeout_pulse
);

    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_RLD =
        RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CUR_MAX = CW'(NUM_FIELDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                  r_state;
    logic [8*NUM_FIELDS-1:0] r_fields;
    logic [8*NUM_FIELDS-1:0] r_edit;
    logic [CW-1:0]           r_cursor;
    logic                    r_editing;
    logic                    r_commit;
    logic                    r_timeout;
    logic [6:0]              r_hist;
    logic [RW-1:0]           r_rpt;
    logic [TW-1:0]           r_to;

    // bit order: 0 enter, 1 done, 2 cancel, 3 right, 4 left, 5 up, 6 down
    logic [6:0]      w_lvl;
    logic [6:0]      w_rise;
    logic            w_any;
    logic            w_hi;
    logic            w_one;
    logic            w_dir_edge;
    logic            w_step;
    logic [RW-1:0]   w_rpt_nxt;
    logic [CW+2:0]   w_idx;
    logic [7:0]      w_sel;
    logic [7:0]      w_min;
    logic [7:0]      w_max;
    logic [7:0]      w_new;

    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v, input logic [7:0] mn, input logic [7:0] mx);
        if (v >= mx || v[7:4] > 4'd9 || v[3:0] > 4'd9) return mn;
        else if (v[3:0] == 4'd9) return v + 8'h07;
        else return v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(
        input logic [7:0] v, input logic [7:0] mn, input logic [7:0] mx);
        if (v <= mn || v[7:4] > 4'd9 || v[3:0] > 4'd9) return mx;
        else if (v[3:0] == 4'd0) return v - 8'h07;
        else return v - 8'h01;
    endfunction

    assign w_lvl = {btn_down, btn_up, btn_left, btn_right,
                    btn_cancel, btn_done, btn_enter};
    assign w_rise = w_lvl & ~r_hist;
    assign w_any  = |w_lvl;
    assign w_hi   = |w_rise[4:1];
    assign w_one  = btn_up ^ btn_down;
    assign w_dir_edge = (btn_up & w_rise[5]) | (btn_down & w_rise[6]);

    assign w_idx = {r_cursor, 3'b000};
    assign w_sel = r_edit[w_idx +: 8];
    assign w_min = FIELD_MIN[w_idx +: 8];
    assign w_max = FIELD_MAX[w_idx +: 8];
    assign w_new = btn_up ? bcd_inc(w_sel, w_min, w_max)
                          : bcd_dec(w_sel, w_min, w_max);

    // Repeat counter only starts on a fresh edge, so a button held
    // through reset (no edge seen) never steps.
    always_comb begin
        w_step    = 1'b0;
        w_rpt_nxt = r_rpt;
        if (!w_one) begin
            w_rpt_nxt = '0;
        end else if (w_dir_edge) begin
            w_step    = 1'b1;
            w_rpt_nxt = RW'(1);
        end else if (r_rpt == '0) begin
            w_rpt_nxt = '0;
        end else if (r_rpt == RPT_DLY) begin
            w_step    = 1'b1;
            w_rpt_nxt = RPT_RLD;
        end else begin
            w_rpt_nxt = r_rpt + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_fields  <= RESET_VAL;
            r_edit    <= RESET_VAL;
            r_cursor  <= '0;
            r_editing <= 1'b0;
            r_commit  <= 1'b0;
            r_timeout <= 1'b0;
            r_hist    <= '1;
            r_rpt     <= '0;
            r_to      <= '0;
        end else begin
            r_hist    <= w_lvl;
            r_commit  <= 1'b0;
            r_timeout <= 1'b0;
            r_rpt     <= '0;
            r_to      <= '0;
            unique case (r_state)
                IDLE: begin
                    if (ext_load) r_fields <= ext_fields;
                    if (w_rise[0]) begin
                        r_edit    <= r_fields;
                        r_cursor  <= '0;
                        r_editing <= 1'b1;
                        r_state   <= EDIT;
                    end
                end
                EDIT: begin
                    if (ext_load) r_fields <= ext_fields;
                    r_rpt <= w_rpt_nxt;
                    if (w_any) r_to <= '0;
                    else if (r_to != TO_MAX) r_to <= r_to + TW'(1);
                    if (!w_any && r_to == TO_MAX) begin
                        r_timeout <= 1'b1;
                        r_editing <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_rise[1]) begin
                        r_editing <= 1'b0;
                        r_state   <= COMMIT;
                    end else if (w_rise[2]) begin
                        r_editing <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_rise[3]) begin
                        r_cursor <= (r_cursor == CUR_MAX) ?
                                    '0 : r_cursor + CW'(1);
                    end else if (w_rise[4]) begin
                        r_cursor <= (r_cursor == '0) ?
                                    CUR_MAX : r_cursor - CW'(1);
                    end else if (w_step && !w_hi) begin
                        r_edit[w_idx +: 8] <= w_new;
                    end
                end
                COMMIT: begin
                    r_fields <= r_edit;
                    r_commit <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_editing <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign fields        = r_fields;
    assign edit_fields   = r_edit;
    assign cursor        = r_cursor;
    assign editing       = r_editing;
    assign commit_pulse  = r_commit;
    assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_bcd_field_editor.sv
// tb_bcd_field_editor: directed self-checking bench for bcd_field_editor.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_bcd_field_editor;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  b;
    logic        ext_load;
    logic [47:0] ext_fields;
    logic [47:0] fields;
    logic [47:0] edit_fields;
    logic [2:0]  cursor;
    logic        editing;
    logic        commit_pulse;
    logic        timeout_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [47:0] RST = 48'h000101000000;
    localparam logic [47:0] LIVE = 48'h241231235958;

    always #5 clk = ~clk;

    bcd_field_editor dut (
        .clk          (clk),
        .reset        (reset),
        .btn_enter    (b[0]),
        .btn_done     (b[1]),
        .btn_cancel   (b[2]),
        .btn_right    (b[3]),
        .btn_left     (b[4]),
        .btn_up       (b[5]),
        .btn_down     (b[6]),
        .ext_load     (ext_load),
        .ext_fields   (ext_fields),
        .fields       (fields),
        .edit_fields  (edit_fields),
        .cursor       (cursor),
        .editing      (editing),
        .commit_pulse (commit_pulse),
        .timeout_pulse(timeout_pulse)
    );

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int i);
        b[i] = 1'b1;
        tick(1);
        b[i] = 1'b0;
        tick(1);
    endtask

    initial begin
        reset = 1'b1;
        b = '0;
        ext_load = 1'b0;
        ext_fields = '0;
        tick(3);
        check("rst_fields", fields, RST);
        check("rst_edit", edit_fields, RST);
        check("rst_cursor", 48'(cursor), 48'd0);
        check("rst_editing", 48'(editing), 48'd0);
        check("rst_commit", 48'(commit_pulse), 48'd0);
        check("rst_timeout", 48'(timeout_pulse), 48'd0);
        reset = 1'b0;
        tick(1);

        // load hour=22 while idle, then hold up
        ext_fields = 48'h000101000022;
        ext_load = 1'b1;
        tick(1);
        ext_load = 1'b0;
        check("idle_load", fields, 48'h000101000022);
        press(0);
        check("enter_editing", 48'(editing), 48'd1);
        check("enter_copy", edit_fields, 48'h000101000022);
        b[5] = 1'b1;
        tick(1);
        check("up_first", 48'(edit_fields[7:0]), 48'h23);
        tick(15);
        check("up_delay", 48'(edit_fields[7:0]), 48'h23);
        tick(1);
        check("up_rpt1", 48'(edit_fields[7:0]), 48'h00);
        tick(4);
        check("up_rpt2", 48'(edit_fields[7:0]), 48'h01);
        tick(19);
        check("up_rpt_end", 48'(edit_fields[7:0]), 48'h05);
        b[5] = 1'b0;
        tick(1);
        press(1);
        check("commit_pulse", 48'(commit_pulse), 48'd1);
        check("commit_fields", fields, 48'h000101000005);
        tick(1);
        check("commit_once", 48'(commit_pulse), 48'd0);

        // month and day stepping
        press(0);
        press(4);
        check("left_wrap", 48'(cursor), 48'd5);
        press(4);
        press(6);
        check("month_dn", 48'(edit_fields[39:32]), 48'h12);
        press(5);
        check("month_up1", 48'(edit_fields[39:32]), 48'h01);
        press(5);
        check("month_up2", 48'(edit_fields[39:32]), 48'h02);
        press(4);
        for (int i = 0; i < 8; i++) press(5);
        check("day_09", 48'(edit_fields[31:24]), 48'h09);
        press(5);
        check("day_10", 48'(edit_fields[31:24]), 48'h10);
        press(6);
        check("day_back09", 48'(edit_fields[31:24]), 48'h09);
        press(2);
        check("cancel1_idle", 48'(editing), 48'd0);
        check("cancel1_fields", fields, 48'h000101000005);

        // cursor wrap and priority
        press(0);
        press(4);
        check("cur_left", 48'(cursor), 48'd5);
        for (int i = 0; i < 6; i++) press(3);
        check("cur_right6", 48'(cursor), 48'd5);
        b[3] = 1'b1;
        b[4] = 1'b1;
        tick(1);
        b = '0;
        tick(1);
        check("cur_rl_prio", 48'(cursor), 48'd0);

        // ext load during edit
        ext_fields = LIVE;
        ext_load = 1'b1;
        tick(1);
        ext_load = 1'b0;
        check("edit_load_f", fields, LIVE);
        check("edit_load_e", edit_fields, 48'h000101000005);
        check("edit_load_ed", 48'(editing), 48'd1);
        press(2);

        // minute 59 -> 00 then cancel
        press(0);
        press(3);
        press(5);
        check("min_wrap", 48'(edit_fields[15:8]), 48'h00);
        b[2] = 1'b1;
        tick(1);
        b[2] = 1'b0;
        check("cancel2_idle", 48'(editing), 48'd0);
        tick(1);
        check("cancel2_nocm", 48'(commit_pulse), 48'd0);
        check("cancel2_f", 48'(fields[15:8]), 48'h59);

        // inactivity timeout
        press(0);
        tick(1022);
        check("to_before", 48'(editing), 48'd1);
        tick(1);
        check("to_idle", 48'(editing), 48'd0);
        check("to_pulse", 48'(timeout_pulse), 48'd1);
        tick(1);
        check("to_once", 48'(timeout_pulse), 48'd0);
        check("to_fields", fields, LIVE);

        // up held through reset release
        b[5] = 1'b1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        press(0);
        tick(20);
        check("held_rst", 48'(edit_fields[7:0]), 48'h00);
        b[5] = 1'b0;
        tick(1);
        press(5);
        check("held_repress", 48'(edit_fields[7:0]), 48'h01);

        // reset during commit
        b[1] = 1'b1;
        tick(1);
        check("in_commit", 48'(editing), 48'd0);
        b[1] = 1'b0;
        reset = 1'b1;
        tick(1);
        check("rstc_fields", fields, RST);
        check("rstc_pulse", 48'(commit_pulse), 48'd0);
        reset = 1'b0;
        tick(2);
        check("rstc_fields2", fields, RST);
        check("rstc_pulse2", 48'(commit_pulse), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
